// File: rtl/mod_n_count_checker.sv
// Mod-N count stream checker: classifies each sample step, locks, flags wraps/errors.
// Optional MOD_N_CHECK_HOLD_ERR_EN: a held count counts as an error step.
module mod_n_count_checker #(
  parameter int WIDTH      = 2,
  parameter int N          = 3,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_LIMIT  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_Q,
  output logic             o_lock,
  output logic             o_dir,
  output logic             o_wrap,
  output logic             o_err,
  output logic [7:0]       o_wrap_cnt,
  output logic [1:0]       o_state
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);

  localparam logic [31:0] NU  = 32'(N);
  localparam logic [31:0] NM1 = 32'(N - 1);
  localparam logic [31:0] LCU = 32'(LOCK_COUNT);
  localparam logic [31:0] ELU = 32'(ERR_LIMIT);

`ifdef MOD_N_CHECK_HOLD_ERR_EN
  localparam bit HOLD_ERR = 1'b1;
`else
  localparam bit HOLD_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    K_ERR,
    K_HOLD,
    K_UP,
    K_UPW,
    K_DN,
    K_DNW
  } kind_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [GW-1:0]    good_q, good_d;
  logic [EW-1:0]    errc_q, errc_d;
  logic             lock_q, lock_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [7:0]       wcnt_q, wcnt_d;

  logic [31:0]      q32;
  logic [31:0]      p32;
  kind_e            kind;
  logic             q_ok;
  logic             legal;
  logic             up;
  logic             wrapk;
  logic [GW-1:0]    good_inc;
  logic [EW-1:0]    errc_inc;

  // Priority order matters for N == 2, where up and down steps coincide.
  always_comb begin
    q32  = 32'(i_Q);
    p32  = 32'(ref_q);
    q_ok = (q32 < NU);
    kind = K_ERR;
    if (!q_ok)
      kind = K_ERR;
    else if (q32 == p32)
      kind = K_HOLD;
    else if ((p32 < NM1) && (q32 == p32 + 32'd1))
      kind = K_UP;
    else if ((p32 == NM1) && (q32 == 32'd0))
      kind = K_UPW;
    else if ((p32 > 32'd0) && (q32 == p32 - 32'd1))
      kind = K_DN;
    else if ((p32 == 32'd0) && (q32 == NM1))
      kind = K_DNW;
    else
      kind = K_ERR;
  end

  always_comb begin
    legal    = (kind == K_UP) || (kind == K_UPW) ||
               (kind == K_DN) || (kind == K_DNW);
    up       = (kind == K_UP) || (kind == K_UPW);
    wrapk    = (kind == K_UPW) || (kind == K_DNW);
    good_inc = good_q + GW'(1);
    errc_inc = errc_q + EW'(1);
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    good_d  = good_q;
    errc_d  = errc_q;
    dir_d   = dir_q;
    wcnt_d  = wcnt_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && q_ok) begin
          ref_d   = i_Q;
          good_d  = '0;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (i_valid) begin
          if (legal) begin
            good_d = good_inc;
            ref_d  = i_Q;
            dir_d  = up;
            if (32'(good_inc) >= LCU) begin
              state_d = ST_LOCKED;
              errc_d  = '0;
            end
          end else if (kind == K_HOLD) begin
            if (HOLD_ERR)
              good_d = '0;
          end else begin
            good_d = '0;
            if (q_ok)
              ref_d = i_Q;
            else
              state_d = ST_IDLE;
          end
        end
      end
      ST_LOCKED: begin
        if (i_valid) begin
          if (legal) begin
            errc_d = '0;
            ref_d  = i_Q;
            dir_d  = up;
            if (wrapk) begin
              wrap_d = 1'b1;
              if (wcnt_q != 8'hFF)
                wcnt_d = wcnt_q + 8'd1;
            end
          end else if ((kind == K_HOLD) && !HOLD_ERR) begin
            errc_d = errc_q;
          end else begin
            err_d  = 1'b1;
            errc_d = errc_inc;
            if (32'(errc_inc) >= ELU) begin
              if (q_ok) begin
                state_d = ST_SYNC;
                good_d  = '0;
                ref_d   = i_Q;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ref_q   <= '0;
      good_q  <= '0;
      errc_q  <= '0;
      lock_q  <= 1'b0;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      good_q  <= good_d;
      errc_q  <= errc_d;
      lock_q  <= lock_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign o_lock     = lock_q;
  assign o_dir      = dir_q;
  assign o_wrap     = wrap_q;
  assign o_err      = err_q;
  assign o_wrap_cnt = wcnt_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_mod_n_count_checker.sv
// Scoreboard bench for mod_n_count_checker (N=3, WIDTH=2).
// Reference model works in modular arithmetic on the count values.
module tb_mod_n_count_checker;

  localparam int W  = 2;
  localparam int N  = 3;
  localparam int LC = 2;
  localparam int EL = 3;

`ifdef MOD_N_CHECK_HOLD_ERR_EN
  localparam bit HOLD_ERR = 1'b1;
`else
  localparam bit HOLD_ERR = 1'b0;
`endif

  localparam int KERR  = 0;
  localparam int KHOLD = 1;
  localparam int KUP   = 2;
  localparam int KUPW  = 3;
  localparam int KDN   = 4;
  localparam int KDNW  = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [W-1:0] qin = '0;
  logic         o_lock, o_dir, o_wrap, o_err;
  logic [7:0]   o_wrap_cnt;
  logic [1:0]   o_state;

  mod_n_count_checker #(
    .WIDTH(W), .N(N), .LOCK_COUNT(LC), .ERR_LIMIT(EL)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_valid(valid),
    .i_Q(qin),
    .o_lock(o_lock),
    .o_dir(o_dir),
    .o_wrap(o_wrap),
    .o_err(o_err),
    .o_wrap_cnt(o_wrap_cnt),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lock;
    logic       dir;
    logic       wrap;
    logic       err;
    logic [7:0] wcnt;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_state, m_ref, m_good, m_errc, m_dir, m_wcnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int classify(input int p, input int q);
    int d;
    if (q >= N) return KERR;
    if (q == p) return KHOLD;
    d = (q - p + N) % N;
    if (d == 1) return (q == 0) ? KUPW : KUP;
    if (d == N - 1) return (q == N - 1) ? KDNW : KDN;
    return KERR;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ref = 0; m_good = 0;
    m_errc = 0; m_dir = 1; m_wcnt = 0;
  endtask

  task automatic model(input bit v, input int qv, output exp_t e);
    int k;
    bit w, er;
    w = 1'b0;
    er = 1'b0;
    if (v) begin
      k = classify(m_ref, qv);
      case (m_state)
        0: begin
          if (qv < N) begin
            m_ref = qv; m_good = 0; m_state = 1;
          end
        end
        1: begin
          if (k >= KUP) begin
            m_good++;
            m_ref = qv;
            m_dir = (k == KUP || k == KUPW) ? 1 : 0;
            if (m_good >= LC) begin
              m_state = 2; m_errc = 0;
            end
          end else if (k == KHOLD) begin
            if (HOLD_ERR) m_good = 0;
          end else begin
            m_good = 0;
            if (qv < N) m_ref = qv;
            else m_state = 0;
          end
        end
        default: begin
          if (k == KHOLD && HOLD_ERR) k = KERR;
          if (k >= KUP) begin
            m_errc = 0;
            m_ref = qv;
            m_dir = (k == KUP || k == KUPW) ? 1 : 0;
            if (k == KUPW || k == KDNW) begin
              w = 1'b1;
              if (m_wcnt < 255) m_wcnt++;
            end
          end else if (k == KERR) begin
            er = 1'b1;
            m_errc++;
            if (m_errc >= EL) begin
              if (qv < N) begin
                m_state = 1; m_good = 0; m_ref = qv;
              end else begin
                m_state = 0;
              end
            end
          end
        end
      endcase
    end
    e.lock = (m_state == 2);
    e.dir  = m_dir[0];
    e.wrap = w;
    e.err  = er;
    e.wcnt = 8'(m_wcnt);
    e.st   = 2'(m_state);
  endtask

  task automatic step(input bit v, input int qv);
    exp_t e;
    valid = v;
    qin   = W'(qv);
    model(v, qv, e);
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("lock", int'(o_lock), int'(e.lock));
      chk("dir", int'(o_dir), int'(e.dir));
      chk("wrap", int'(o_wrap), int'(e.wrap));
      chk("err", int'(o_err), int'(e.err));
      chk("wrap_cnt", int'(o_wrap_cnt), int'(e.wcnt));
      chk("state", int'(o_state), int'(e.st));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_lock"}, int'(o_lock), 0);
    chk({tag, "_dir"}, int'(o_dir), 1);
    chk({tag, "_wrap"}, int'(o_wrap), 0);
    chk({tag, "_err"}, int'(o_err), 0);
    chk({tag, "_wcnt"}, int'(o_wrap_cnt), 0);
    chk({tag, "_state"}, int'(o_state), 0);
  endtask

  initial begin
    int r, nq;
    model_reset();
    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    #1 rst = 1'b0;

    // scenario 1: lock and up-wrap
    step(1, 0); step(1, 1); step(1, 2); step(1, 0);
    // scenario 2: down-wrap and down step
    step(1, 2); step(1, 1);
    // scenario 3: three out-of-range samples drop to idle
    step(1, 3); step(1, 3); step(1, 3);
    // relock and park at ref 1
    step(1, 0); step(1, 1); step(1, 2); step(1, 0); step(1, 1);
    // scenario 4: holds then a legal step
    step(1, 1); step(1, 1); step(1, 2);
    // idle cycles change nothing
    for (int i = 0; i < 5; i++) step(0, $urandom_range(0, 3));

    // scenario 5: asynchronous reset between edges
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("async");
    model_reset();
    #1 rst = 1'b0;
    step(1, 1); step(1, 2); step(1, 0);

    // scenario 6: saturating wrap counter
    for (int i = 0; i < 300; i++) begin
      step(1, 1); step(1, 2); step(1, 0);
    end
    @(negedge clk);
    #1;
    chk("wrap_sat", int'(o_wrap_cnt), 255);

    // random stream: mostly legal steps, some holds, errors and bursts
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r >= 97) begin
        for (int j = 0; j < EL; j++) step(1, 3);
      end else begin
        if (r < 70)
          nq = ($urandom_range(0, 1) == 1) ? (m_ref + 1) % N
                                           : (m_ref + N - 1) % N;
        else if (r < 80)
          nq = m_ref;
        else
          nq = $urandom_range(0, 3);
        step(($urandom_range(0, 9) != 0), nq);
      end
    end

    repeat (2) @(negedge clk);
    #1;
    chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
